// File: rtl/lc3b_types.sv
// Shared types and default widths for the memory arbiter slice.
package lc3b_types;

  localparam int unsigned ADDR_W_DEF  = 12;
  localparam int unsigned DATA_W_DEF  = 128;
  localparam int unsigned SEL_W_DEF   = 16;
  localparam int unsigned TIMEOUT_DEF = 255;

  typedef enum logic [1:0] {
    StIdle,
    StGrantI,
    StGrantD
  } arb_state_e;

  typedef enum logic {
    LastFetch,
    LastData
  } last_grant_e;

endpackage

// File: rtl/arb_watchdog.sv
// Grant wait counter: expired is high in the cycle the wait count reaches TIMEOUT.
module arb_watchdog
  import lc3b_types::*;
#(
  parameter int unsigned TIMEOUT = TIMEOUT_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int unsigned CntW = $clog2(TIMEOUT + 1);

  logic [CntW-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (enable && (count_q != CntW'(TIMEOUT))) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  // count_q holds the wait cycles already spent, so this cycle is the TIMEOUT-th one.
  assign expired = enable & ~clear & (count_q == CntW'(TIMEOUT - 1));

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one downstream memory port between fetch and data masters.
module mem_arbiter
  import lc3b_types::*;
#(
  parameter int unsigned ADDR_W  = ADDR_W_DEF,
  parameter int unsigned DATA_W  = DATA_W_DEF,
  parameter int unsigned SEL_W   = SEL_W_DEF,
  parameter int unsigned TIMEOUT = TIMEOUT_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_cyc,
  input  logic              i_stb,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_adr,
  input  logic [DATA_W-1:0] i_dat_m,
  input  logic [SEL_W-1:0]  i_sel,
  output logic              i_ack,
  output logic              i_err,
  output logic [DATA_W-1:0] i_dat_s,
  input  logic              d_cyc,
  input  logic              d_stb,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_adr,
  input  logic [DATA_W-1:0] d_dat_m,
  input  logic [SEL_W-1:0]  d_sel,
  output logic              d_ack,
  output logic              d_err,
  output logic [DATA_W-1:0] d_dat_s,
  output logic              m_cyc,
  output logic              m_stb,
  output logic              m_we,
  output logic [ADDR_W-1:0] m_adr,
  output logic [DATA_W-1:0] m_dat_m,
  output logic [SEL_W-1:0]  m_sel,
  input  logic              m_ack,
  input  logic [DATA_W-1:0] m_dat_s
);

  arb_state_e  state_q, state_d;
  last_grant_e last_q, last_d;
  logic        i_req, d_req, expired;

  assign i_req   = i_cyc & i_stb;
  assign d_req   = d_cyc & d_stb;
  assign i_dat_s = m_dat_s;
  assign d_dat_s = m_dat_s;

  arb_watchdog #(
    .TIMEOUT(TIMEOUT)
  ) u_watchdog (
    .clk    (clk),
    .rst    (rst),
    .clear  (state_q == StIdle),
    .enable ((state_q != StIdle) & ~m_ack),
    .expired(expired)
  );

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    m_cyc   = 1'b0;
    m_stb   = 1'b0;
    m_we    = 1'b0;
    m_adr   = '0;
    m_dat_m = '0;
    m_sel   = '0;
    i_ack   = 1'b0;
    i_err   = 1'b0;
    d_ack   = 1'b0;
    d_err   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (i_req && d_req) begin
          state_d = (last_q == LastFetch) ? StGrantD : StGrantI;
        end else if (i_req) begin
          state_d = StGrantI;
        end else if (d_req) begin
          state_d = StGrantD;
        end
      end
      StGrantI: begin
        m_cyc   = i_cyc;
        m_stb   = i_stb;
        m_we    = i_we;
        m_adr   = i_adr;
        m_dat_m = i_dat_m;
        m_sel   = i_sel;
        i_ack   = m_ack;
        i_err   = expired;
        // Ack, abort and timeout all end the grant; round-robin credit is spent either way.
        if (m_ack || !i_req || expired) begin
          state_d = StIdle;
          last_d  = LastFetch;
        end
      end
      StGrantD: begin
        m_cyc   = d_cyc;
        m_stb   = d_stb;
        m_we    = d_we;
        m_adr   = d_adr;
        m_dat_m = d_dat_m;
        m_sel   = d_sel;
        d_ack   = m_ack;
        d_err   = expired;
        if (m_ack || !d_req || expired) begin
          state_d = StIdle;
          last_d  = LastData;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      last_q  <= LastFetch;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter (built with TIMEOUT=4).
module tb_mem_arbiter;

  localparam int unsigned AW = 12;
  localparam int unsigned DW = 128;
  localparam int unsigned SW = 16;
  localparam logic [DW-1:0] RdPat = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;

  logic          clk = 1'b0;
  logic          rst;
  logic          i_cyc, i_stb, i_we, i_ack, i_err;
  logic [AW-1:0] i_adr;
  logic [DW-1:0] i_dat_m, i_dat_s;
  logic [SW-1:0] i_sel;
  logic          d_cyc, d_stb, d_we, d_ack, d_err;
  logic [AW-1:0] d_adr;
  logic [DW-1:0] d_dat_m, d_dat_s;
  logic [SW-1:0] d_sel;
  logic          m_cyc, m_stb, m_we, m_ack;
  logic [AW-1:0] m_adr;
  logic [DW-1:0] m_dat_m, m_dat_s;
  logic [SW-1:0] m_sel;

  int n_checks = 0;
  int n_fail   = 0;

  mem_arbiter #(
    .ADDR_W (AW),
    .DATA_W (DW),
    .SEL_W  (SW),
    .TIMEOUT(4)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .i_cyc  (i_cyc),
    .i_stb  (i_stb),
    .i_we   (i_we),
    .i_adr  (i_adr),
    .i_dat_m(i_dat_m),
    .i_sel  (i_sel),
    .i_ack  (i_ack),
    .i_err  (i_err),
    .i_dat_s(i_dat_s),
    .d_cyc  (d_cyc),
    .d_stb  (d_stb),
    .d_we   (d_we),
    .d_adr  (d_adr),
    .d_dat_m(d_dat_m),
    .d_sel  (d_sel),
    .d_ack  (d_ack),
    .d_err  (d_err),
    .d_dat_s(d_dat_s),
    .m_cyc  (m_cyc),
    .m_stb  (m_stb),
    .m_we   (m_we),
    .m_adr  (m_adr),
    .m_dat_m(m_dat_m),
    .m_sel  (m_sel),
    .m_ack  (m_ack),
    .m_dat_s(m_dat_s)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic clear_inputs();
    i_cyc = 1'b0; i_stb = 1'b0; i_we = 1'b0; i_adr = '0; i_dat_m = '0; i_sel = '0;
    d_cyc = 1'b0; d_stb = 1'b0; d_we = 1'b0; d_adr = '0; d_dat_m = '0; d_sel = '0;
    m_ack = 1'b0;
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    clear_inputs();
    m_dat_s = RdPat;
    i_cyc = 1'b1; i_stb = 1'b1; i_adr = 12'hFFF; i_dat_m = '1; i_sel = '1;
    d_cyc = 1'b1; d_stb = 1'b1; m_ack = 1'b1;
    rst = 1'b1;
    step();
    settle();
    n_checks++;
    if ({m_cyc, m_stb, m_we, m_adr, m_sel, m_dat_m} !== '0) begin
      n_fail++;
      $display("FAIL reset_m_outputs: got %b%b%b adr=%h sel=%h dat=%h want all zero",
               m_cyc, m_stb, m_we, m_adr, m_sel, m_dat_m);
    end
    n_checks++;
    if ({i_ack, i_err, d_ack, d_err} !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_ack_err: got %b want 0000", {i_ack, i_err, d_ack, d_err});
    end
    n_checks++;
    if ((i_dat_s !== RdPat) || (d_dat_s !== RdPat)) begin
      n_fail++;
      $display("FAIL reset_dat_s: got %h/%h want %h", i_dat_s, d_dat_s, RdPat);
    end
    clear_inputs();
    rst = 1'b0;
    step();
  endtask

  task automatic test_fetch_only();
    int acks = 0;
    i_cyc = 1'b1; i_stb = 1'b1; i_we = 1'b0; i_adr = 12'h0A3; i_sel = 16'hFFFF;
    settle();
    n_checks++;
    if (m_stb !== 1'b0) begin
      n_fail++;
      $display("FAIL fetch_idle_stb: got %b want 0", m_stb);
    end
    step(); settle();
    n_checks++;
    if ({m_cyc, m_stb, m_we, m_adr} !== {3'b110, 12'h0A3}) begin
      n_fail++;
      $display("FAIL fetch_grant: got cyc=%b stb=%b we=%b adr=%h want 1 1 0 0a3",
               m_cyc, m_stb, m_we, m_adr);
    end
    acks += int'(i_ack);
    step(); settle();
    acks += int'(i_ack);
    step(); m_ack = 1'b1; settle();
    acks += int'(i_ack);
    n_checks++;
    if (d_ack !== 1'b0) begin
      n_fail++;
      $display("FAIL fetch_d_ack: got %b want 0", d_ack);
    end
    step(); m_ack = 1'b0; i_cyc = 1'b0; i_stb = 1'b0; settle();
    acks += int'(i_ack);
    n_checks++;
    if (acks != 1) begin
      n_fail++;
      $display("FAIL fetch_ack_count: got %0d want 1", acks);
    end
    n_checks++;
    if (m_cyc !== 1'b0) begin
      n_fail++;
      $display("FAIL fetch_return_idle: got m_cyc=%b want 0", m_cyc);
    end
  endtask

  task automatic test_idle_ack();
    m_ack = 1'b1;
    for (int k = 0; k < 2; k++) begin
      settle();
      n_checks++;
      if ({i_ack, i_err, d_ack, d_err} !== 4'b0000) begin
        n_fail++;
        $display("FAIL idle_ack_ignored: got %b want 0000", {i_ack, i_err, d_ack, d_err});
      end
      step();
    end
    m_ack = 1'b0;
  endtask

  task automatic test_round_robin();
    pulse_reset();
    d_cyc = 1'b1; d_stb = 1'b1; d_adr = 12'h100;
    i_cyc = 1'b1; i_stb = 1'b1; i_adr = 12'h200;
    step(); m_ack = 1'b1; settle();
    n_checks++;
    if ({m_adr, d_ack, i_ack} !== {12'h100, 2'b10}) begin
      n_fail++;
      $display("FAIL rr_data_first: got adr=%h d_ack=%b i_ack=%b want 100 1 0",
               m_adr, d_ack, i_ack);
    end
    step(); m_ack = 1'b0; d_cyc = 1'b0; d_stb = 1'b0; settle();
    n_checks++;
    if ({m_cyc, m_stb} !== 2'b00) begin
      n_fail++;
      $display("FAIL rr_idle_gap: got cyc=%b stb=%b want 0 0", m_cyc, m_stb);
    end
    step(); m_ack = 1'b1; settle();
    n_checks++;
    if ({m_adr, i_ack, d_ack} !== {12'h200, 2'b10}) begin
      n_fail++;
      $display("FAIL rr_fetch_second: got adr=%h i_ack=%b d_ack=%b want 200 1 0",
               m_adr, i_ack, d_ack);
    end
    step(); clear_inputs();
  endtask

  task automatic test_data_write();
    logic [DW-1:0] exp_dat;
    exp_dat = 128'hBEEF << 16;
    d_cyc = 1'b1; d_stb = 1'b1; d_we = 1'b1; d_adr = 12'h3C5; d_sel = 16'h000C;
    d_dat_m = 128'hBEEF << 16;
    i_we = 1'b1; i_sel = 16'hFFFF; i_dat_m = '1; i_adr = 12'hAAA;
    step(); settle();
    n_checks++;
    if ({m_cyc, m_stb, m_we, m_adr, m_sel} !== {3'b111, 12'h3C5, 16'h000C}) begin
      n_fail++;
      $display("FAIL write_ctrl: got %b%b%b adr=%h sel=%h want 111 3c5 000c",
               m_cyc, m_stb, m_we, m_adr, m_sel);
    end
    n_checks++;
    if (m_dat_m !== exp_dat) begin
      n_fail++;
      $display("FAIL write_data: got %h want %h", m_dat_m, exp_dat);
    end
    step(); m_ack = 1'b1; settle();
    n_checks++;
    if ({d_ack, m_we, m_sel} !== {2'b11, 16'h000C}) begin
      n_fail++;
      $display("FAIL write_ack: got d_ack=%b we=%b sel=%h want 1 1 000c", d_ack, m_we, m_sel);
    end
    step(); clear_inputs();
  endtask

  task automatic test_timeout();
    i_cyc = 1'b1; i_stb = 1'b1; i_adr = 12'h055;
    step();
    for (int k = 1; k <= 3; k++) begin
      settle();
      n_checks++;
      if ({i_err, m_stb} !== 2'b01) begin
        n_fail++;
        $display("FAIL timeout_early_cycle%0d: got err=%b stb=%b want 0 1", k, i_err, m_stb);
      end
      step();
    end
    settle();
    n_checks++;
    if ({i_err, d_err, i_ack} !== 3'b100) begin
      n_fail++;
      $display("FAIL timeout_err_pulse: got i_err=%b d_err=%b i_ack=%b want 1 0 0",
               i_err, d_err, i_ack);
    end
    i_cyc = 1'b0; i_stb = 1'b0;
    step(); settle();
    n_checks++;
    if ({i_err, m_cyc} !== 2'b00) begin
      n_fail++;
      $display("FAIL timeout_to_idle: got err=%b cyc=%b want 0 0", i_err, m_cyc);
    end
    clear_inputs();
  endtask

  task automatic test_abort();
    d_cyc = 1'b1; d_stb = 1'b1; d_adr = 12'h111;
    i_cyc = 1'b1; i_stb = 1'b1; i_adr = 12'h222;
    step(); settle();
    n_checks++;
    if ({m_stb, m_adr} !== {1'b1, 12'h111}) begin
      n_fail++;
      $display("FAIL abort_grant_d: got stb=%b adr=%h want 1 111", m_stb, m_adr);
    end
    d_stb = 1'b0; settle();
    n_checks++;
    if ({m_stb, d_ack, d_err} !== 3'b000) begin
      n_fail++;
      $display("FAIL abort_stb_drop: got stb=%b ack=%b err=%b want 0 0 0", m_stb, d_ack, d_err);
    end
    step(); settle();
    n_checks++;
    if ({m_cyc, m_stb} !== 2'b00) begin
      n_fail++;
      $display("FAIL abort_idle: got cyc=%b stb=%b want 0 0", m_cyc, m_stb);
    end
    step(); m_ack = 1'b1; settle();
    n_checks++;
    if ({m_stb, m_adr, i_ack} !== {1'b1, 12'h222, 1'b1}) begin
      n_fail++;
      $display("FAIL abort_fetch_next: got stb=%b adr=%h i_ack=%b want 1 222 1",
               m_stb, m_adr, i_ack);
    end
    step(); clear_inputs();
  endtask

  task automatic test_reset_mid_grant();
    i_cyc = 1'b1; i_stb = 1'b1; i_we = 1'b1; i_adr = 12'h077; i_sel = 16'h00FF;
    i_dat_m = 128'h5555;
    step(); settle();
    n_checks++;
    if ({m_stb, m_adr} !== {1'b1, 12'h077}) begin
      n_fail++;
      $display("FAIL rstmid_granted: got stb=%b adr=%h want 1 077", m_stb, m_adr);
    end
    #1 rst = 1'b1;
    m_ack = 1'b1;
    #1;
    n_checks++;
    if ({m_cyc, m_stb, m_we, m_adr, m_sel, m_dat_m} !== '0) begin
      n_fail++;
      $display("FAIL rstmid_m_zero: got %b%b%b adr=%h sel=%h dat=%h want all zero",
               m_cyc, m_stb, m_we, m_adr, m_sel, m_dat_m);
    end
    n_checks++;
    if ({i_ack, i_err, d_ack, d_err} !== 4'b0000) begin
      n_fail++;
      $display("FAIL rstmid_no_ack: got %b want 0000", {i_ack, i_err, d_ack, d_err});
    end
    step();
    rst = 1'b0;
    clear_inputs();
    step(); settle();
    n_checks++;
    if ({m_cyc, i_ack, i_err} !== 3'b000) begin
      n_fail++;
      $display("FAIL rstmid_after: got cyc=%b ack=%b err=%b want 0 0 0", m_cyc, i_ack, i_err);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation ran past 100000 time units");
    $fatal(1, "bench timed out");
  end

  initial begin
    test_reset();
    test_fetch_only();
    test_idle_ack();
    test_round_robin();
    test_data_write();
    test_timeout();
    test_abort();
    test_reset_mid_grant();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
